fetch_queue: RTL and testbench

- Parametrised successor to the single-entry fetch stage.
- Streams sequential instruction reads to memory and buffers up to DEPTH fetched instructions with their PCs in a queue.
- Presents the oldest entry to decode under a valid/stall handshake.
- Handles redirect (flush) and instruction-address misalignment.
- Sits between the instruction memory port and the decode stage.

---
 rtl/fetch_queue_pkg.sv | 23 ++
 rtl/fetch_queue_fifo.sv | 79 +++++++
 rtl/fetch_queue.sv | 146 ++++++++++++++
 tb/tb_fetch_queue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared fetch definitions (def_params: sizes, exception codes, FSM encodings)
`ifndef FETCH_QUEUE_DEF_PARAMS
`define FETCH_QUEUE_DEF_PARAMS
`define ADDR_SIZE 32
`define INSTR_SIZE 32
`define EX_WIDTH 3
`define EX_INSTR_ADDR_MISALIGN 4'd0
`endif

package fetch_queue_pkg;

    localparam int DEF_ADDR_W  = `ADDR_SIZE;
    localparam int DEF_INSTR_W = `INSTR_SIZE;
    localparam int EX_W        = `EX_WIDTH + 1;

    localparam logic [EX_W-1:0] EX_MISALIGN = `EX_INSTR_ADDR_MISALIGN;

    typedef enum logic {
        FQ_IDLE = 1'b0,
        FQ_REQ  = 1'b1
    } fq_state_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// rtl/fetch_queue_fifo.sv - fetch_fifo: DEPTH-entry queue with a registered head entry
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_next;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head_next;

    assign empty   = (count == '0);
    assign full    = (count == CNT_FULL);
    assign rd_next = rd_ptr + PTR_ONE;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // The head register always mirrors the entry that will be oldest after this edge.
    always_comb begin
        head_next = head;
        if (do_pop) begin
            if (count > CNT_ONE) begin
                head_next = mem[rd_next];
            end else if (do_push) begin
                head_next = push_data;
            end
        end else if (empty && do_push) begin
            head_next = push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            head <= head_next;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch_queue top: request FSM, fetch PC, halt/flush; FETCH_STATS_EN adds counters
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INSTR_W  = DEF_INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    output logic               mem_rd_enable,
    input  logic [INSTR_W-1:0] mem_rd_data,
    input  logic               mem_rd_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  PC,
    output logic [EX_W-1:0]    exception,
    output logic               exception_valid,
    output logic               pipeline_valid,
    input  logic               stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  flush_addr
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_starved
`endif
);

    localparam int PW    = $clog2(DEPTH);
    localparam int ENT_W = ADDR_W + INSTR_W + EX_W + 1;
    localparam logic [PW:0]       CNT_LAST = (PW+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(4);

    fq_state_t          state;
    fq_state_t          state_next;
    logic [ADDR_W-1:0]  fetch_pc;
    logic               fetch_halted;
    logic [PW:0]        occ;
    logic               fifo_full;
    logic               fifo_empty;
    logic               can_issue;
    logic               pc_misaligned;
    logic               pop_now;
    logic               accept;
    logic               misalign_push;
    logic               push;
    logic [ENT_W-1:0]   push_data;
    logic [ENT_W-1:0]   head;

    assign can_issue     = !fifo_full && !flush && !fetch_halted;
    assign pc_misaligned = (fetch_pc[1:0] != 2'b00);
    assign pipeline_valid = !fifo_empty;
    assign pop_now       = pipeline_valid && !stall;
    assign mem_rd_addr   = fetch_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FQ_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving REQ only when this response takes the last free slot.
    always_comb begin
        state_next = state;
        case (state)
            FQ_IDLE: if (can_issue && !pc_misaligned) state_next = FQ_REQ;
            FQ_REQ:  if (mem_rd_ready && !pop_now && occ == CNT_LAST) state_next = FQ_IDLE;
            default: state_next = FQ_IDLE;
        endcase
        if (flush) begin
            state_next = FQ_IDLE;
        end
    end

    always_comb begin
        mem_rd_enable = (state == FQ_REQ);
        accept        = 1'b0;
        misalign_push = 1'b0;
        if (!flush) begin
            accept        = (state == FQ_REQ) && mem_rd_ready;
            misalign_push = (state == FQ_IDLE) && can_issue && pc_misaligned;
        end
        push = accept || misalign_push;
        if (accept) begin
            push_data = {fetch_pc, mem_rd_data, {EX_W{1'b0}}, 1'b0};
        end else begin
            push_data = {fetch_pc, {INSTR_W{1'b0}}, EX_MISALIGN, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            fetch_halted <= 1'b0;
        end else if (flush) begin
            fetch_pc     <= flush_addr;
            fetch_halted <= 1'b0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (misalign_push) begin
                fetch_halted <= 1'b1;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop_now),
        .clear     (flush),
        .head      (head),
        .count     (occ),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {PC, instr, exception, exception_valid} = head;

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_fetched <= '0;
            stat_starved <= '0;
        end else begin
            if (accept) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (!pipeline_valid) begin
                stat_starved <= stat_starved + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue with a latency-configurable memory model
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem_rd_addr;
    logic        mem_rd_enable;
    logic [31:0] mem_rd_data = '0;
    logic        mem_rd_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] PC;
    logic [3:0]  exception;
    logic        exception_valid;
    logic        pipeline_valid;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] flush_addr = '0;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_starved;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        excv;
        logic [3:0]  exc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mem_wait = 0;
    int   mem_budget = 1 << 30;
    int   wait_cnt = 0;

    fetch_queue dut (
        .clk             (clk),
        .reset           (reset),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_enable   (mem_rd_enable),
        .mem_rd_data     (mem_rd_data),
        .mem_rd_ready    (mem_rd_ready),
        .instr           (instr),
        .PC              (PC),
        .exception       (exception),
        .exception_valid (exception_valid),
        .pipeline_valid  (pipeline_valid),
        .stall           (stall),
        .flush           (flush),
        .flush_addr      (flush_addr)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched    (stat_fetched),
        .stat_starved    (stat_starved)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_q.push_back('{pc: pc, ins: instr_of(pc), excv: 1'b0, exc: 4'd0});
    endtask

    // Memory answers a held request after mem_wait idle cycles, within a response budget.
    always @(negedge clk) begin
        if (mem_rd_enable && mem_budget > 0 && wait_cnt >= mem_wait) begin
            mem_rd_ready = 1'b1;
            mem_rd_data  = instr_of(mem_rd_addr);
            wait_cnt     = 0;
            mem_budget--;
        end else begin
            mem_rd_ready = 1'b0;
            if (mem_rd_enable) wait_cnt++;
            else wait_cnt = 0;
        end
    end

    // Monitor: every head that will pop at the next edge is matched against the scoreboard.
    always begin
        @(negedge clk);
        #3;
        if (!reset && !flush && pipeline_valid && !stall) begin
            if (exp_q.size() == 0) begin
                check("unexpected_head_pc", PC, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("head_pc", PC, e.pc);
                check("head_instr", instr, e.ins);
                check("head_exc_valid", exception_valid, e.excv);
                check("head_exc", exception, e.exc);
            end
        end
    end

    task automatic do_reset(input logic st);
        @(negedge clk);
        reset = 1'b1;
        flush = 1'b0;
        stall = st;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            @(negedge clk);
            k++;
        end
        stall = 1'b1;
        check("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        @(negedge clk);
        #1;
        check("rst_enable", mem_rd_enable, 0);
        check("rst_addr", mem_rd_addr, 0);
        check("rst_valid", pipeline_valid, 0);
        check("rst_instr", instr, 0);
        check("rst_pc", PC, 0);
        check("rst_exc", exception, 0);
        check("rst_exc_valid", exception_valid, 0);

        // Streaming, memory always ready, no stall
        do_reset(1'b0);
        for (int i = 0; i < 6; i++) expect_fetch(32'(4 * i));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("stream_enable", mem_rd_enable, 1);
            check("stream_addr", mem_rd_addr, 64'(4 * i));
            check("stream_valid", pipeline_valid, (i > 0) ? 1 : 0);
        end
        wait_drain(50);

        // Stall fills exactly DEPTH entries, then drains in order
        do_reset(1'b1);
        repeat (10) @(negedge clk);
        #1;
        check("full_enable_low", mem_rd_enable, 0);
        check("full_next_addr", mem_rd_addr, 32'h10);
        check("full_head_pc", PC, 0);
        check("full_valid", pipeline_valid, 1);
        for (int i = 0; i < 6; i++) expect_fetch(32'(4 * i));
        stall = 1'b0;
        wait_drain(60);

        // Memory delays 3 cycles: request held stable, single enqueue
        mem_wait = 3;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("wait_enable", mem_rd_enable, 1);
            check("wait_addr", mem_rd_addr, 0);
            check("wait_valid", pipeline_valid, 0);
        end
        @(negedge clk);
        #1;
        check("wait_one_enq_valid", pipeline_valid, 1);
        check("wait_next_addr", mem_rd_addr, 4);
        expect_fetch(32'h0);
        expect_fetch(32'h4);
        stall = 1'b0;
        wait_drain(60);
        mem_wait = 0;

        // Flush in the same cycle as a memory response
        do_reset(1'b0);
        @(negedge clk);
        flush_addr = 32'h100;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_enable_low", mem_rd_enable, 0);
        check("flush_valid_low", pipeline_valid, 0);
        check("flush_addr_loaded", mem_rd_addr, 32'h100);
        for (int i = 0; i < 3; i++) expect_fetch(32'h100 + 32'(4 * i));
        @(negedge clk);
        #1;
        check("flush_reissue_enable", mem_rd_enable, 1);
        check("flush_reissue_addr", mem_rd_addr, 32'h100);
        wait_drain(50);

        // Flush while stalled with a full queue
        repeat (6) @(negedge clk);
        #1;
        check("stallfull_valid", pipeline_valid, 1);
        check("stallfull_enable", mem_rd_enable, 0);
        check("stallfull_head", PC, 32'h10C);
        @(negedge clk);
        flush_addr = 32'h300;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("stallflush_valid", pipeline_valid, 0);
        check("stallflush_addr", mem_rd_addr, 32'h300);
        expect_fetch(32'h300);
        expect_fetch(32'h304);
        stall = 1'b0;
        wait_drain(50);

        // Misaligned redirect halts fetch until the next flush
        do_reset(1'b0);
        @(negedge clk);
        flush_addr = 32'h102;
        flush = 1'b1;
        exp_q.push_back('{pc: 32'h102, ins: 32'h0, excv: 1'b1, exc: 4'd0});
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            check("halt_no_read", mem_rd_enable, 0);
        end
        check("halt_queue_empty", pipeline_valid, 0);
        @(negedge clk);
        flush_addr = 32'h200;
        flush = 1'b1;
        expect_fetch(32'h200);
        expect_fetch(32'h204);
        @(negedge clk);
        flush = 1'b0;
        wait_drain(50);

`ifdef FETCH_STATS_EN
        // Statistics: five responses, survive flush, cleared by reset
        mem_budget = 5;
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) expect_fetch(32'(4 * i));
        wait_drain(50);
        repeat (3) @(negedge clk);
        #1;
        check("stat_fetched_5", stat_fetched, 5);
        @(negedge clk);
        flush_addr = 32'h40;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("stat_fetched_after_flush", stat_fetched, 5);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("stat_fetched_reset", stat_fetched, 0);
        check("stat_starved_reset", stat_starved, 0);
        mem_budget = 1 << 30;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
